// File: rtl/ebr_ctrl_pkg.sv
// Shared types, CTI codes and helpers for the wb_ebr_port Wishbone front end.
package ebr_ctrl_pkg;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned SEL_MAX_W = 32;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RMW   = 2'd1,
        ST_ACK   = 2'd2,
        ST_BURST = 2'd3
    } state_e;

    // True when every one of the low 'lanes' select bits is set.
    function automatic logic sel_full(input logic [SEL_MAX_W-1:0] sel,
                                      input int unsigned lanes);
        logic full;
        full = 1'b1;
        for (int unsigned i = 0; i < SEL_MAX_W; i++) begin
            if ((i < lanes) && !sel[i]) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

endpackage

// File: rtl/ebr_byte_merge.sv
// Per-byte-lane merge of new write data over the old RAM word.
module ebr_byte_merge
    import ebr_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH-1:0]   old_data,
    output logic [DATA_WIDTH-1:0]   merged_c
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_W;

    // Selected lanes take the new byte, others keep the RAM byte.
    always_comb begin
        merged_c = old_data;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (sel[i]) begin
                merged_c[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/wb_ebr_port.sv
// Wishbone B3 slave front end for the dual-address blockram: classic and
// incrementing bursts, with read-modify-write for byte-lane writes.
module wb_ebr_port
    import ebr_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic [31:0]             EBR_ADR_I,
    input  logic [DATA_WIDTH-1:0]   EBR_DAT_I,
    output logic [DATA_WIDTH-1:0]   EBR_DAT_O,
    input  logic [DATA_WIDTH/8-1:0] EBR_SEL_I,
    input  logic                    EBR_WE_I,
    input  logic                    EBR_STB_I,
    input  logic                    EBR_CYC_I,
    input  logic [2:0]              EBR_CTI_I,
    output logic                    EBR_ACK_O,
    output logic                    EBR_ERR_O,
    output logic                    EBR_RTY_O,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
    output logic                    ram_we,
    output logic [DATA_WIDTH-1:0]   ram_wr_data,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / LANE_W;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   burst_addr_q, burst_addr_d;

    logic                    req_c;
    logic                    full_c;
    logic                    partial_wr_c;
    logic [2:0]              cti_c;
    logic [ADDR_WIDTH-1:0]   adr_word_c;
    logic [DATA_WIDTH-1:0]   merged_c;

    logic                    ack_c;
    logic                    we_c;
    logic [ADDR_WIDTH-1:0]   rd_addr_c;
    logic [ADDR_WIDTH-1:0]   wr_addr_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;

    logic                    unused_adr_c;

    assign req_c        = EBR_CYC_I & EBR_STB_I;
    assign full_c       = sel_full(SEL_MAX_W'(EBR_SEL_I), SEL_WIDTH);
    assign partial_wr_c = EBR_WE_I & ~full_c;
    assign adr_word_c   = EBR_ADR_I[ADDR_WIDTH+1:2];
    assign unused_adr_c = ^{EBR_ADR_I[31:ADDR_WIDTH+2], EBR_ADR_I[1:0]};

    // Reserved CTI codes behave as classic cycles.
    assign cti_c = ((EBR_CTI_I == CTI_INCR) || (EBR_CTI_I == CTI_END))
                   ? EBR_CTI_I : CTI_CLASSIC;

    ebr_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .sel      (EBR_SEL_I),
        .new_data (EBR_DAT_I),
        .old_data (ram_rd_data),
        .merged_c (merged_c)
    );

    // Next-state, address counter and RAM/bus control decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        burst_addr_d = burst_addr_q;
        ack_c        = 1'b0;
        we_c         = 1'b0;
        rd_addr_c    = adr_word_c;
        wr_addr_c    = adr_word_c;
        wr_data_c    = EBR_DAT_I;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    addr_d = adr_word_c;
                    if (!EBR_WE_I) begin
                        state_d = ST_ACK;
                    end else if (full_c) begin
                        we_c    = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_RMW;
                    end
                end
            end

            ST_RMW: begin
                // Old word is on ram_rd_data now; commit only if the master stayed.
                rd_addr_c = addr_q;
                wr_addr_c = addr_q;
                wr_data_c = merged_c;
                if (req_c) begin
                    we_c    = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACK: begin
                ack_c     = 1'b1;
                wr_addr_c = addr_q;
                // Look ahead one word so a burst read has data next cycle.
                rd_addr_c = addr_q + ADDR_WIDTH'(1);
                if ((cti_c == CTI_INCR) && req_c && !(EBR_WE_I && !full_c)) begin
                    burst_addr_d = addr_q + ADDR_WIDTH'(1);
                    state_d      = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BURST: begin
                wr_addr_c = burst_addr_q;
                rd_addr_c = burst_addr_q + ADDR_WIDTH'(1);
                if (!req_c) begin
                    state_d = ST_IDLE;
                end else if (partial_wr_c) begin
                    // Byte-lane beat: fetch the current word and merge next cycle.
                    rd_addr_c = burst_addr_q;
                    addr_d    = burst_addr_q;
                    state_d   = ST_RMW;
                end else begin
                    ack_c        = 1'b1;
                    we_c         = EBR_WE_I;
                    burst_addr_d = burst_addr_q + ADDR_WIDTH'(1);
                    if (cti_c != CTI_INCR) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and address registers.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            burst_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            burst_addr_q <= burst_addr_d;
        end
    end

    // Reset masks bus and RAM strobes immediately, not at the next edge.
    assign EBR_ACK_O   = ack_c & ~RST_I;
    assign EBR_DAT_O   = (ack_c & ~RST_I) ? ram_rd_data : '0;
    assign EBR_ERR_O   = 1'b0;
    assign EBR_RTY_O   = 1'b0;
    assign ram_we      = we_c & ~RST_I;
    assign ram_rd_addr = RST_I ? '0 : rd_addr_c;
    assign ram_wr_addr = RST_I ? '0 : wr_addr_c;
    assign ram_wr_data = RST_I ? '0 : wr_data_c;

endmodule

// File: tb/tb_wb_ebr_port.sv
// Directed bench for wb_ebr_port with a behavioural registered-read blockram.
module tb_wb_ebr_port;

    logic        CLK_I;
    logic        RST_I;
    logic [31:0] EBR_ADR_I;
    logic [31:0] EBR_DAT_I;
    logic [31:0] EBR_DAT_O;
    logic [3:0]  EBR_SEL_I;
    logic        EBR_WE_I;
    logic        EBR_STB_I;
    logic        EBR_CYC_I;
    logic [2:0]  EBR_CTI_I;
    logic        EBR_ACK_O;
    logic        EBR_ERR_O;
    logic        EBR_RTY_O;
    logic [7:0]  ram_wr_addr;
    logic [7:0]  ram_rd_addr;
    logic        ram_we;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_rd_data;

    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    int errors = 0;
    int checks = 0;

    wb_ebr_port #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .EBR_ADR_I   (EBR_ADR_I),
        .EBR_DAT_I   (EBR_DAT_I),
        .EBR_DAT_O   (EBR_DAT_O),
        .EBR_SEL_I   (EBR_SEL_I),
        .EBR_WE_I    (EBR_WE_I),
        .EBR_STB_I   (EBR_STB_I),
        .EBR_CYC_I   (EBR_CYC_I),
        .EBR_CTI_I   (EBR_CTI_I),
        .EBR_ACK_O   (EBR_ACK_O),
        .EBR_ERR_O   (EBR_ERR_O),
        .EBR_RTY_O   (EBR_RTY_O),
        .ram_wr_addr (ram_wr_addr),
        .ram_rd_addr (ram_rd_addr),
        .ram_we      (ram_we),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    // Blockram model: one write port, registered read port, bench preload path.
    always @(posedge CLK_I) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic drive_idle();
        EBR_CYC_I = 1'b0;
        EBR_STB_I = 1'b0;
        EBR_WE_I  = 1'b0;
        EBR_SEL_I = 4'h0;
        EBR_CTI_I = 3'b000;
        EBR_ADR_I = 32'h0;
        EBR_DAT_I = 32'h0;
    endtask

    task automatic preload(input int unsigned w, input logic [31:0] d);
        @(posedge CLK_I); #1;
        pre_we   = 1'b1;
        pre_addr = 8'(w);
        pre_data = d;
        @(posedge CLK_I); #1;
        pre_we   = 1'b0;
    endtask

    // Classic read; reports which cycle (0 = request cycle) carried the ack.
    task automatic classic_read(input logic [31:0] adr, output logic [31:0] data,
                                output int ack_cyc);
        @(posedge CLK_I); #1;
        EBR_CYC_I = 1'b1;
        EBR_STB_I = 1'b1;
        EBR_WE_I  = 1'b0;
        EBR_SEL_I = 4'hF;
        EBR_CTI_I = 3'b000;
        EBR_ADR_I = adr;
        ack_cyc   = -1;
        data      = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK_I);
            if (EBR_ACK_O) begin
                data    = EBR_DAT_O;
                ack_cyc = k;
                break;
            end
            @(posedge CLK_I); #1;
        end
        @(posedge CLK_I); #1;
        drive_idle();
    endtask

    task automatic test_reset();
        RST_I     = 1'b1;
        EBR_CYC_I = 1'b1;
        EBR_STB_I = 1'b1;
        EBR_WE_I  = 1'b1;
        EBR_SEL_I = 4'hF;
        EBR_ADR_I = 32'h0000_0010;
        EBR_DAT_I = 32'h1234_5678;
        repeat (2) @(posedge CLK_I);
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", EBR_ACK_O); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", ram_we); end
        checks++; if (EBR_DAT_O !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", EBR_DAT_O); end
        checks++; if (ram_rd_addr !== 8'h0) begin errors++; $display("FAIL rst_rd_addr: got %h want 0", ram_rd_addr); end
        checks++; if (ram_wr_addr !== 8'h0) begin errors++; $display("FAIL rst_wr_addr: got %h want 0", ram_wr_addr); end
        checks++; if ({EBR_ERR_O, EBR_RTY_O} !== 2'b00) begin errors++; $display("FAIL rst_err_rty: got %b want 00", {EBR_ERR_O, EBR_RTY_O}); end
        drive_idle();
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
    endtask

    task automatic test_classic_write();
        @(posedge CLK_I); #1;
        EBR_CYC_I = 1'b1; EBR_STB_I = 1'b1; EBR_WE_I = 1'b1;
        EBR_SEL_I = 4'hF; EBR_CTI_I = 3'b000;
        EBR_ADR_I = 32'h0000_0010; EBR_DAT_I = 32'hDEAD_BEEF;
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b0) begin errors++; $display("FAIL cw_ack_c0: got %b want 0", EBR_ACK_O); end
        checks++; if (ram_we !== 1'b1 || ram_wr_addr !== 8'd4) begin errors++; $display("FAIL cw_ram_c0: got we=%b addr=%0d want we=1 addr=4", ram_we, ram_wr_addr); end
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b1) begin errors++; $display("FAIL cw_ack_c1: got %b want 1", EBR_ACK_O); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL cw_we_c1: got %b want 0", ram_we); end
        @(posedge CLK_I); #1;
        drive_idle();
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b0) begin errors++; $display("FAIL cw_ack_c2: got %b want 0", EBR_ACK_O); end
        checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cw_mem: got %h want deadbeef", mem[4]); end
    endtask

    task automatic test_classic_read();
        logic [31:0] d;
        int          c;
        classic_read(32'h0000_0010, d, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL cr_ack_cycle: got %0d want 1", c); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cr_data: got %h want deadbeef", d); end
    endtask

    task automatic test_partial_write();
        logic [31:0] d;
        int          c;
        preload(4, 32'h1122_3344);
        @(posedge CLK_I); #1;
        EBR_CYC_I = 1'b1; EBR_STB_I = 1'b1; EBR_WE_I = 1'b1;
        EBR_SEL_I = 4'b0001; EBR_CTI_I = 3'b000;
        EBR_ADR_I = 32'h0000_0010; EBR_DAT_I = 32'h0000_00AA;
        @(negedge CLK_I);
        checks++; if (ram_we !== 1'b0 || EBR_ACK_O !== 1'b0) begin errors++; $display("FAIL pw_c0: got we=%b ack=%b want 0 0", ram_we, EBR_ACK_O); end
        @(negedge CLK_I);
        checks++; if (ram_we !== 1'b1 || EBR_ACK_O !== 1'b0) begin errors++; $display("FAIL pw_c1: got we=%b ack=%b want 1 0", ram_we, EBR_ACK_O); end
        checks++; if (ram_wr_data !== 32'h1122_33AA || ram_wr_addr !== 8'd4) begin errors++; $display("FAIL pw_merge: got %h@%0d want 112233aa@4", ram_wr_data, ram_wr_addr); end
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL pw_c2: got ack=%b we=%b want 1 0", EBR_ACK_O, ram_we); end
        @(posedge CLK_I); #1;
        drive_idle();
        classic_read(32'h0000_0010, d, c);
        checks++; if (d !== 32'h1122_33AA || c !== 1) begin errors++; $display("FAIL pw_readback: got %h (cycle %0d) want 112233aa (cycle 1)", d, c); end
    endtask

    task automatic test_burst_read();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hFE00_00FE;
        exp_d[1] = 32'hFF00_00FF;
        exp_d[2] = 32'h0A0B_0C0D;
        exp_d[3] = 32'h1111_0001;
        preload(254, exp_d[0]);
        preload(255, exp_d[1]);
        preload(0, exp_d[2]);
        preload(1, exp_d[3]);
        @(posedge CLK_I); #1;
        EBR_CYC_I = 1'b1; EBR_STB_I = 1'b1; EBR_WE_I = 1'b0;
        EBR_SEL_I = 4'hF; EBR_CTI_I = 3'b010;
        EBR_ADR_I = 32'h0000_03F8;
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b0) begin errors++; $display("FAIL br_ack_c0: got %b want 0", EBR_ACK_O); end
        for (int b = 0; b < 4; b++) begin
            @(negedge CLK_I);
            checks++; if (EBR_ACK_O !== 1'b1) begin errors++; $display("FAIL br_ack beat %0d: got %b want 1", b, EBR_ACK_O); end
            checks++; if (EBR_DAT_O !== exp_d[b]) begin errors++; $display("FAIL br_data beat %0d: got %h want %h", b, EBR_DAT_O, exp_d[b]); end
            @(posedge CLK_I); #1;
            if (b < 3) begin
                EBR_ADR_I = EBR_ADR_I + 32'd4;
                EBR_CTI_I = (b == 2) ? 3'b111 : 3'b010;
            end else begin
                drive_idle();
            end
        end
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b0) begin errors++; $display("FAIL br_ack_after: got %b want 0", EBR_ACK_O); end
    endtask

    task automatic test_burst_write();
        logic [31:0] wd [3];
        wd[0] = 32'hCAFE_0008;
        wd[1] = 32'hCAFE_0009;
        wd[2] = 32'hCAFE_000A;
        @(posedge CLK_I); #1;
        EBR_CYC_I = 1'b1; EBR_STB_I = 1'b1; EBR_WE_I = 1'b1;
        EBR_SEL_I = 4'hF; EBR_CTI_I = 3'b010;
        EBR_ADR_I = 32'h0000_0020; EBR_DAT_I = wd[0];
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b0) begin errors++; $display("FAIL bw_ack_c0: got %b want 0", EBR_ACK_O); end
        for (int b = 0; b < 3; b++) begin
            @(negedge CLK_I);
            checks++; if (EBR_ACK_O !== 1'b1) begin errors++; $display("FAIL bw_ack beat %0d: got %b want 1", b, EBR_ACK_O); end
            @(posedge CLK_I); #1;
            if (b < 2) begin
                EBR_ADR_I = EBR_ADR_I + 32'd4;
                EBR_DAT_I = wd[b+1];
                EBR_CTI_I = (b == 1) ? 3'b111 : 3'b010;
            end else begin
                drive_idle();
            end
        end
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL bw_after: got ack=%b we=%b want 0 0", EBR_ACK_O, ram_we); end
        for (int b = 0; b < 3; b++) begin
            checks++; if (mem[8+b] !== wd[b]) begin errors++; $display("FAIL bw_mem word %0d: got %h want %h", 8 + b, mem[8+b], wd[b]); end
        end
    endtask

    task automatic test_rmw_abort();
        int we_pulses;
        int acks;
        preload(12, 32'h5566_7788);
        @(posedge CLK_I); #1;
        EBR_CYC_I = 1'b1; EBR_STB_I = 1'b1; EBR_WE_I = 1'b1;
        EBR_SEL_I = 4'b0010; EBR_CTI_I = 3'b000;
        EBR_ADR_I = 32'h0000_0030; EBR_DAT_I = 32'h0000_BB00;
        @(negedge CLK_I);
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ab_we_c0: got %b want 0", ram_we); end
        @(posedge CLK_I); #1;
        EBR_CYC_I = 1'b0;
        we_pulses = 0;
        acks      = 0;
        repeat (3) begin
            @(negedge CLK_I);
            if (ram_we) we_pulses++;
            if (EBR_ACK_O) acks++;
        end
        drive_idle();
        checks++; if (we_pulses !== 0) begin errors++; $display("FAIL ab_we_pulses: got %0d want 0", we_pulses); end
        checks++; if (acks !== 0) begin errors++; $display("FAIL ab_acks: got %0d want 0", acks); end
        checks++; if (mem[12] !== 32'h5566_7788) begin errors++; $display("FAIL ab_mem: got %h want 55667788", mem[12]); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d;
        int          c;
        preload(16, 32'h0);
        preload(17, 32'h1717_1717);
        @(posedge CLK_I); #1;
        EBR_CYC_I = 1'b1; EBR_STB_I = 1'b1; EBR_WE_I = 1'b1;
        EBR_SEL_I = 4'hF; EBR_CTI_I = 3'b010;
        EBR_ADR_I = 32'h0000_0040; EBR_DAT_I = 32'hA0A0_A0A0;
        @(negedge CLK_I);
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b1) begin errors++; $display("FAIL rb_ack_c1: got %b want 1", EBR_ACK_O); end
        @(posedge CLK_I); #1;
        EBR_ADR_I = 32'h0000_0044; EBR_DAT_I = 32'hB1B1_B1B1;
        @(negedge CLK_I);
        checks++; if (EBR_ACK_O !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL rb_beat1: got ack=%b we=%b want 1 1", EBR_ACK_O, ram_we); end
        #2;
        RST_I = 1'b1;
        #1;
        checks++; if (EBR_ACK_O !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL rb_async: got ack=%b we=%b want 0 0", EBR_ACK_O, ram_we); end
        @(posedge CLK_I); #1;
        drive_idle();
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        checks++; if (mem[17] !== 32'h1717_1717) begin errors++; $display("FAIL rb_mem17: got %h want 17171717", mem[17]); end
        checks++; if (mem[16] !== 32'hA0A0_A0A0) begin errors++; $display("FAIL rb_mem16: got %h want a0a0a0a0", mem[16]); end
        classic_read(32'h0000_0010, d, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL rb_read_cycle: got %0d want 1", c); end
        checks++; if (d !== 32'h1122_33AA) begin errors++; $display("FAIL rb_read_data: got %h want 112233aa", d); end
    endtask

    initial begin
        pre_we   = 1'b0;
        pre_addr = 8'h0;
        pre_data = 32'h0;
        RST_I    = 1'b1;
        drive_idle();
        test_reset();
        test_classic_write();
        test_classic_read();
        test_partial_write();
        test_burst_read();
        test_burst_write();
        test_rmw_abort();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
